// File: rtl/mor1kx_tlb_reload_arb.sv
// Arbiter that merges the IMMU and DMMU TLB-reload page-table reads onto one
// Wishbone B3 classic read-only master port. Errors and timeouts return a zero word.
module mor1kx_tlb_reload_arb #(
    parameter int    OPTION_OPERAND_WIDTH = 32,
    parameter int    OPTION_TIMEOUT       = 255,
    parameter string ARB_PRIORITY         = "ROUND_ROBIN"
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,

    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,

    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    output logic                            bus_err_o,

    output logic [1:0]                      dbg_state
);

    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam int CW = (OPTION_TIMEOUT > 0) ? $clog2(OPTION_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST    = CW'((OPTION_TIMEOUT > 0) ? OPTION_TIMEOUT - 1 : 0);
    localparam logic [OW-1:0] ADR_MASK   = ~OW'(3);
    localparam bit            DMMU_FIRST = (ARB_PRIORITY == "DMMU_FIRST");

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IMMU, OWN_DMMU} owner_t;

    state_t        state;
    owner_t        owner;
    logic          last_dmmu;
    logic          aborted;
    logic [CW-1:0] cnt;

    logic          grant_immu;
    logic          grant_dmmu;
    logic          owner_req;
    logic          timed_out;
    logic          bus_done;
    logic          bus_fail;
    logic [OW-1:0] fetched;

    // Requester handshake: req is a level held for the whole walk; the arbiter
    // answers each read with a one-cycle ack carrying data, after which the
    // requester may present the next address or drop req to end the walk.
    always_comb begin
        grant_immu = 1'b0;
        grant_dmmu = 1'b0;
        if (owner == OWN_IMMU && immu_req_i) begin
            grant_immu = 1'b1;
        end else if (owner == OWN_DMMU && dmmu_req_i) begin
            grant_dmmu = 1'b1;
        end else if (immu_req_i && dmmu_req_i) begin
            if (DMMU_FIRST || !last_dmmu) grant_dmmu = 1'b1;
            else                          grant_immu = 1'b1;
        end else if (immu_req_i) begin
            grant_immu = 1'b1;
        end else if (dmmu_req_i) begin
            grant_dmmu = 1'b1;
        end
    end

    always_comb begin
        owner_req = 1'b0;
        if (owner == OWN_IMMU) owner_req = immu_req_i;
        if (owner == OWN_DMMU) owner_req = dmmu_req_i;
    end

    assign timed_out = (OPTION_TIMEOUT != 0) && (cnt == TO_LAST);
    assign bus_done  = wbm_ack_i || wbm_err_i || timed_out;
    assign bus_fail  = !wbm_ack_i && (wbm_err_i || timed_out);
    assign fetched   = bus_fail ? '0 : wbm_dat_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            owner       <= OWN_NONE;
            last_dmmu   <= 1'b0;
            aborted     <= 1'b0;
            cnt         <= '0;
            wbm_adr_o   <= '0;
            wbm_cyc_o   <= 1'b0;
            immu_ack_o  <= 1'b0;
            dmmu_ack_o  <= 1'b0;
            immu_data_o <= '0;
            dmmu_data_o <= '0;
            bus_err_o   <= 1'b0;
        end else begin
            immu_ack_o <= 1'b0;
            dmmu_ack_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_immu || grant_dmmu) begin
                        owner     <= grant_dmmu ? OWN_DMMU : OWN_IMMU;
                        last_dmmu <= grant_dmmu;
                        wbm_adr_o <= (grant_dmmu ? dmmu_addr_i : immu_addr_i) & ADR_MASK;
                        wbm_cyc_o <= 1'b1;
                        cnt       <= '0;
                        aborted   <= 1'b0;
                        state     <= S_BUS;
                    end else if (!immu_req_i && !dmmu_req_i) begin
                        owner <= OWN_NONE;
                    end
                end
                S_BUS: begin
                    // A walk abandoned mid-cycle still completes on the bus;
                    // only the answer to the requester is dropped.
                    if (!owner_req) aborted <= 1'b1;
                    if (bus_done) begin
                        wbm_cyc_o <= 1'b0;
                        bus_err_o <= bus_fail;
                        state     <= S_DONE;
                        if (owner_req && !aborted) begin
                            if (owner == OWN_IMMU) begin
                                immu_ack_o  <= 1'b1;
                                immu_data_o <= fetched;
                            end else begin
                                dmmu_ack_o  <= 1'b1;
                                dmmu_data_o <= fetched;
                            end
                        end else begin
                            owner <= OWN_NONE;
                        end
                    end else if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hf;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;
    assign dbg_state = state;

endmodule

// File: tb/tb_mor1kx_tlb_reload_arb.sv
// Bench for mor1kx_tlb_reload_arb: a round-robin instance with a short timeout
// and a DMMU-first instance without timeout, each behind a simple Wishbone slave.
module tb_mor1kx_tlb_reload_arb;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // index [k][r]: k = instance (0 round robin, 1 dmmu first), r = 0 IMMU / 1 DMMU
  logic         req  [2][2];
  logic [W-1:0] addr [2][2];
  logic         ack  [2][2];
  logic [W-1:0] data [2][2];
  logic [W-1:0] adr [2];
  logic         cyc [2];
  logic         stb [2];
  logic         we [2];
  logic [3:0]   sel [2];
  logic [2:0]   cti [2];
  logic [1:0]   bte [2];
  logic [W-1:0] dat_i [2];
  logic         ack_i [2];
  logic         err_i [2];
  logic         bus_err [2];
  logic [1:0]   dbg [2];

  mor1kx_tlb_reload_arb #(.OPTION_OPERAND_WIDTH(W), .OPTION_TIMEOUT(8), .ARB_PRIORITY("ROUND_ROBIN")) dut_rr (
    .clk(clk), .rst(rst),
    .immu_req_i(req[0][0]), .immu_addr_i(addr[0][0]), .immu_ack_o(ack[0][0]), .immu_data_o(data[0][0]),
    .dmmu_req_i(req[0][1]), .dmmu_addr_i(addr[0][1]), .dmmu_ack_o(ack[0][1]), .dmmu_data_o(data[0][1]),
    .wbm_adr_o(adr[0]), .wbm_cyc_o(cyc[0]), .wbm_stb_o(stb[0]), .wbm_we_o(we[0]), .wbm_sel_o(sel[0]),
    .wbm_cti_o(cti[0]), .wbm_bte_o(bte[0]), .wbm_dat_i(dat_i[0]), .wbm_ack_i(ack_i[0]),
    .wbm_err_i(err_i[0]), .bus_err_o(bus_err[0]), .dbg_state(dbg[0]));

  mor1kx_tlb_reload_arb #(.OPTION_OPERAND_WIDTH(W), .OPTION_TIMEOUT(0), .ARB_PRIORITY("DMMU_FIRST")) dut_df (
    .clk(clk), .rst(rst),
    .immu_req_i(req[1][0]), .immu_addr_i(addr[1][0]), .immu_ack_o(ack[1][0]), .immu_data_o(data[1][0]),
    .dmmu_req_i(req[1][1]), .dmmu_addr_i(addr[1][1]), .dmmu_ack_o(ack[1][1]), .dmmu_data_o(data[1][1]),
    .wbm_adr_o(adr[1]), .wbm_cyc_o(cyc[1]), .wbm_stb_o(stb[1]), .wbm_we_o(we[1]), .wbm_sel_o(sel[1]),
    .wbm_cti_o(cti[1]), .wbm_bte_o(bte[1]), .wbm_dat_i(dat_i[1]), .wbm_ack_i(ack_i[1]),
    .wbm_err_i(err_i[1]), .bus_err_o(bus_err[1]), .dbg_state(dbg[1]));

  int total = 0;
  int bad = 0;
  logic [W:0] exp_q[$];
  logic [W:0] exp_df_q[$];

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_2000;
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1};
  endfunction

  // ---------------- slave: mode 0 ack, 1 err, 2 silent, 3 ack+err ----------------
  int slv_mode [2];
  int slv_lat [2];
  int scnt [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ack_i[k] <= 1'b0;
      err_i[k] <= 1'b0;
      if (!rst && cyc[k] === 1'b1 && !ack_i[k] && !err_i[k]) begin
        scnt[k] <= scnt[k] + 1;
        if (slv_mode[k] != 2 && scnt[k] == slv_lat[k] - 2) begin
          ack_i[k] <= (slv_mode[k] != 1);
          err_i[k] <= (slv_mode[k] != 0);
          dat_i[k] <= (slv_mode[k] == 1) ? 32'hBAD0_BAD0 : mem_word(adr[k]);
        end
      end else begin
        scnt[k] <= 0;
      end
    end
  end

  // ---------------- monitor and scoreboard ----------------
  logic         cyc_prev [2] = '{1'b0, 1'b0};
  logic [W-1:0] adr_prev [2];
  int cyc_run [2], cyc_len [2], rise_cyc [2], gap [2], done_i_cyc [2], berr_cnt [2];
  int req_cyc [2][2];
  int ack_seen_cyc [2][2];
  logic [W:0] got;
  logic [W:0] e;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cyc[k] === 1'b1) begin
        if (!cyc_prev[k]) begin
          rise_cyc[k] = cycle;
          gap[k] = cycle - done_i_cyc[k];
          cyc_run[k] = 0;
        end
        cyc_run[k]++;
        total++;
        if (stb[k] !== 1'b1 || we[k] !== 1'b0 || sel[k] !== 4'hf || cti[k] !== 3'b000 ||
            bte[k] !== 2'b00 || adr[k][1:0] !== 2'b00 || (cyc_prev[k] && adr[k] !== adr_prev[k])) begin
          bad++;
          $display("FAIL bus_protocol inst%0d adr=%h stb=%b we=%b sel=%h cti=%h bte=%h prev_adr=%h",
                   k, adr[k], stb[k], we[k], sel[k], cti[k], bte[k], adr_prev[k]);
        end
        if (ack_i[k] || err_i[k]) done_i_cyc[k] = cycle;
      end else if (cyc_prev[k]) begin
        cyc_len[k] = cyc_run[k];
      end
      cyc_prev[k] = (cyc[k] === 1'b1);
      adr_prev[k] = adr[k];
      if (bus_err[k] === 1'b1) berr_cnt[k]++;
      for (int r = 0; r < 2; r++) begin
        if (ack[k][r] === 1'b1) begin
          got = {r[0], data[k][r]};
          total++;
          if (k == 0) begin
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL sb_unexpected inst0 got=%h exp=none", got);
            end else begin
              e = exp_q.pop_front();
              if (got !== e) begin
                bad++;
                $display("FAIL sb_data inst0 got=%h exp=%h", got, e);
              end
            end
          end else begin
            if (exp_df_q.size() == 0) begin
              bad++;
              $display("FAIL sb_unexpected inst1 got=%h exp=none", got);
            end else begin
              e = exp_df_q.pop_front();
              if (got !== e) begin
                bad++;
                $display("FAIL sb_data inst1 got=%h exp=%h", got, e);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver: one reload walk of n reads ----------------
  task automatic walk(input int k, input int r, input logic [W-1:0] a0, input logic [W-1:0] a1, input int n);
    int waited;
    addr[k][r] = a0;
    req[k][r] = 1'b1;
    req_cyc[k][r] = cycle;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (ack[k][r] !== 1'b1 && waited < 100);
      total++;
      if (ack[k][r] !== 1'b1) begin
        bad++;
        $display("FAIL walk_ack inst%0d req%0d got=%b exp=1 within 100 cycles", k, r, ack[k][r]);
      end
      ack_seen_cyc[k][r] = cycle;
      addr[k][r] = a1 + W'(4 * i);
    end
    req[k][r] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (cyc[k] !== 1'b0 || stb[k] !== 1'b0 || adr[k] !== '0 || bus_err[k] !== 1'b0 || dbg[k] !== 2'd0) begin
        bad++;
        $display("FAIL %s_bus inst%0d cyc=%b stb=%b adr=%h bus_err=%b state=%0d exp all 0",
                 tag, k, cyc[k], stb[k], adr[k], bus_err[k], dbg[k]);
      end
      for (int r = 0; r < 2; r++) begin
        total++;
        if (ack[k][r] !== 1'b0 || data[k][r] !== '0) begin
          bad++;
          $display("FAIL %s_req inst%0d req%0d ack=%b data=%h exp 0/0", tag, k, r, ack[k][r], data[k][r]);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_dmmu();
    slv_mode[0] = 0;
    slv_lat[0] = 3;
    exp_q.push_back({1'b1, 32'hDEAD_2000});
    walk(0, 1, 32'h0000_1004, 32'h0000_1004, 1);
    repeat (3) @(negedge clk);
    total++;
    if (cyc_len[0] !== 3) begin bad++; $display("FAIL single_cyc_len got=%0d exp=3", cyc_len[0]); end
    total++;
    if (rise_cyc[0] - req_cyc[0][1] !== 1) begin
      bad++; $display("FAIL single_req_to_cyc got=%0d exp=1", rise_cyc[0] - req_cyc[0][1]);
    end
    total++;
    if (ack_seen_cyc[0][1] - done_i_cyc[0] !== 1) begin
      bad++; $display("FAIL single_ack_latency got=%0d exp=1", ack_seen_cyc[0][1] - done_i_cyc[0]);
    end
    total++;
    if (data[0][1] !== 32'hDEAD_2000 || data[0][0] !== '0) begin
      bad++; $display("FAIL single_data_hold dmmu=%h immu=%h exp dead2000/0", data[0][1], data[0][0]);
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    slv_lat[0] = 2;
    exp_q.push_back({1'b1, mem_word(32'h2000)});
    exp_q.push_back({1'b0, mem_word(32'h3000)});
    fork
      walk(0, 1, 32'h2000, 32'h2000, 1);
      walk(0, 0, 32'h3000, 32'h3000, 1);
    join
    @(negedge clk);
    total++;
    if (gap[0] !== 3) begin bad++; $display("FAIL rr_back_to_back_gap got=%0d exp=3", gap[0]); end
  endtask

  task automatic test_lock();
    slv_lat[0] = 2;
    exp_q.push_back({1'b1, mem_word(32'h0100)});
    exp_q.push_back({1'b1, mem_word(32'h2004)});
    exp_q.push_back({1'b0, mem_word(32'h5000)});
    fork
      walk(0, 1, 32'h0100, 32'h2004, 2);
      begin
        repeat (2) @(negedge clk);
        walk(0, 0, 32'h5003, 32'h5003, 1);
      end
    join
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dmmu_first();
    slv_mode[1] = 0;
    slv_lat[1] = 2;
    exp_df_q.push_back({1'b1, mem_word(32'h6000)});
    walk(1, 1, 32'h6000, 32'h6000, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) exp_df_q.push_back({1'b1, mem_word(32'h4000 + W'(4 * i))});
    exp_df_q.push_back({1'b0, mem_word(32'h7000)});
    fork
      walk(1, 1, 32'h4000, 32'h4004, 4);
      walk(1, 0, 32'h7000, 32'h7000, 1);
    join
    repeat (2) @(negedge clk);
  endtask

  task automatic test_error();
    int b0;
    b0 = berr_cnt[0];
    slv_mode[0] = 1;
    slv_lat[0] = 2;
    exp_q.push_back({1'b1, 32'h0});
    walk(0, 1, 32'h9000, 32'h9000, 1);
    @(negedge clk);
    total++;
    if (berr_cnt[0] !== b0 + 1) begin bad++; $display("FAIL err_pulse got=%0d exp=%0d", berr_cnt[0], b0 + 1); end
  endtask

  task automatic test_ack_priority();
    int b0;
    b0 = berr_cnt[0];
    slv_mode[0] = 3;
    slv_lat[0] = 2;
    exp_q.push_back({1'b1, mem_word(32'hA000)});
    walk(0, 1, 32'hA000, 32'hA000, 1);
    @(negedge clk);
    total++;
    if (berr_cnt[0] !== b0) begin bad++; $display("FAIL ack_over_err_pulse got=%0d exp=%0d", berr_cnt[0], b0); end
  endtask

  task automatic test_timeout();
    int b0;
    b0 = berr_cnt[0];
    slv_mode[0] = 2;
    exp_q.push_back({1'b1, 32'h0});
    walk(0, 1, 32'hB000, 32'hB000, 1);
    @(negedge clk);
    total++;
    if (cyc_len[0] !== 8) begin bad++; $display("FAIL timeout_cyc_len got=%0d exp=8", cyc_len[0]); end
    total++;
    if (berr_cnt[0] !== b0 + 1) begin bad++; $display("FAIL timeout_pulse got=%0d exp=%0d", berr_cnt[0], b0 + 1); end
    total++;
    if (data[0][0] !== mem_word(32'h5000)) begin
      bad++; $display("FAIL timeout_immu_hold got=%h exp=%h", data[0][0], mem_word(32'h5000));
    end
  endtask

  task automatic test_no_timeout();
    slv_mode[1] = 0;
    slv_lat[1] = 20;
    exp_df_q.push_back({1'b1, mem_word(32'hC000)});
    walk(1, 1, 32'hC000, 32'hC000, 1);
    @(negedge clk);
    total++;
    if (cyc_len[1] !== 20) begin bad++; $display("FAIL no_timeout_cyc_len got=%0d exp=20", cyc_len[1]); end
  endtask

  task automatic test_abort();
    int waited;
    int b0;
    b0 = berr_cnt[0];
    slv_mode[0] = 0;
    slv_lat[0] = 4;
    addr[0][1] = 32'h8000;
    req[0][1] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (cyc[0] !== 1'b1 && waited < 20);
    @(negedge clk);
    req[0][1] = 1'b0;
    waited = 0;
    do begin @(negedge clk); waited++; end while (cyc[0] !== 1'b0 && waited < 20);
    repeat (4) @(negedge clk);
    total++;
    if (cyc_len[0] !== 4) begin bad++; $display("FAIL abort_cyc_len got=%0d exp=4", cyc_len[0]); end
    total++;
    if (data[0][1] !== 32'h0 || berr_cnt[0] !== b0) begin
      bad++; $display("FAIL abort_no_update data=%h berr=%0d exp 0/%0d", data[0][1], berr_cnt[0], b0);
    end
  endtask

  task automatic test_reset_mid_bus();
    int waited;
    slv_mode[0] = 2;
    addr[0][1] = 32'hD000;
    req[0][1] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (cyc[0] !== 1'b1 && waited < 20);
    @(negedge clk);
    total++;
    if (cyc[0] !== 1'b1) begin bad++; $display("FAIL mid_bus_setup cyc=%b exp=1", cyc[0]); end
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("mid_bus_reset");
    req[0][1] = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (cyc[0] !== 1'b0) begin bad++; $display("FAIL mid_bus_after cyc=%b exp=0", cyc[0]); end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      slv_mode[k] = 0;
      slv_lat[k] = 2;
      scnt[k] = 0;
      berr_cnt[k] = 0;
      done_i_cyc[k] = 0;
      cyc_len[k] = 0;
      for (int r = 0; r < 2; r++) begin
        req[k][r] = 1'b0;
        addr[k][r] = '0;
      end
    end
    test_reset();
    test_single_dmmu();
    test_round_robin();
    test_lock();
    test_dmmu_first();
    test_error();
    test_ack_priority();
    test_timeout();
    test_no_timeout();
    test_abort();
    test_reset_mid_bus();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover inst0 got=%0d exp=0", exp_q.size()); end
    total++;
    if (exp_df_q.size() != 0) begin bad++; $display("FAIL sb_leftover inst1 got=%0d exp=0", exp_df_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
